fp32_accumulator: RTL
=====================

FP32_ACCUMULATOR -- requirements
Module: fp32_accumulator

Interface
REQ-001 Parameter: CLEAR_ON_OUT, default 1, meaning 1 = accumulator returns to +0 after each result handshake, 0 = running sum retained.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL be cleared immediately when reset is asserted.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  in_data is a valid product from the upstream fp32 multiplier.
REQ-006 Port: in_ready  output  1  block can accept a sample this cycle.
REQ-007 Port: in_data  input  32  IEEE-754 single-precision product.
REQ-008 Port: in_last  input  1  final product of the current dot-product; qualified by in_valid.
REQ-009 Port: out_valid  output  1  out_data holds a completed sum.
REQ-010 Port: out_ready  input  1  downstream accepts out_data.
REQ-011 Port: out_data  output  32  IEEE-754 single-precision accumulated sum.

Function
REQ-012 A sample SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in state IDLE.
REQ-013 FSM states SHALL be IDLE, ALIGN, ADD, NORM, HOLD; transitions: IDLE->ALIGN on accept; ALIGN->ADD; ADD->NORM; NORM->HOLD if the accepted sample had in_last=1, else NORM->IDLE; HOLD->IDLE on out_valid & out_ready.
REQ-014 Each accepted sample SHALL be added to the accumulator register in exactly 3 cycles (ALIGN, ADD, NORM); the next sample is accepted no earlier than the cycle after NORM.
REQ-015 ALIGN: the operand with smaller exponent SHALL have its 24-bit significand (hidden bit restored) right-shifted by the exponent difference; shifts of 25 or more yield zero.
REQ-016 ADD: same signs add magnitudes; differing signs subtract smaller from larger magnitude, result takes sign of larger; equal magnitudes with opposite signs yield +0.
REQ-017 NORM: result SHALL be normalized with a single-cycle leading-one detect, carry-out shifts right by one and increments the exponent; rounding SHALL be truncation (round toward zero).
REQ-018 Inputs with exponent field 0 SHALL be treated as signed zero (denormals flushed); results with exponent underflow (<1) SHALL flush to +0.
REQ-019 A result exponent of 255 or more SHALL saturate to signed infinity (exp=255, mantissa=0); an infinity input SHALL force the accumulator to that infinity; NaN handling is out of scope and undefined.
REQ-020 In HOLD, out_valid SHALL be 1 and out_data SHALL remain stable until out_ready=1; out_valid SHALL drop the cycle after the handshake.
REQ-021 On the HOLD handshake with CLEAR_ON_OUT=1 the accumulator SHALL become 0x00000000; with CLEAR_ON_OUT=0 it SHALL retain the sum.
REQ-022 out_data SHALL equal the accumulator register at all times; it is only qualified when out_valid=1.
REQ-023 in_valid while in_ready=0 SHALL be ignored (upstream must hold data); in_last with in_valid=0 SHALL be ignored.

Reset
REQ-024 While rst_n=0: state=IDLE, accumulator=0x00000000, out_valid=0, in_ready=0; in_ready SHALL rise the first clock edge after rst_n deasserts.
REQ-025 Reset asserted mid-operation (any state, including HOLD) SHALL abandon the sum without producing out_valid.

Verification
REQ-026 Accept 0xC0900000 (-4.5), then 0xC0B00000 (-5.5) with in_last=1, out_ready=1 -> out_valid for one cycle with out_data=0xC1200000 (-10.0), 4 cycles after second accept.
REQ-027 Accept 0x3FC00000 (1.5) then 0xBFC00000 (-1.5, last) -> out_data=0x00000000.
REQ-028 Accept 0x7F7FFFFF then 0x7F7FFFFF (last) -> out_data=0x7F800000 (+inf).
REQ-029 Single sample 0x40400000 with in_last=1, out_ready held 0 for 5 cycles -> out_valid stays 1, out_data=0x40400000 stable, in_ready=0 throughout; release out_ready -> handshake, next result starts from +0.
REQ-030 Hold in_valid=1 continuously across a 3-sample sequence -> exactly one accept per 4 cycles, no sample duplicated or dropped.
REQ-031 Assert rst_n=0 during ADD of the second sample -> out_valid never asserts; after release, 0x3F800000 (1.0, last) -> out_data=0x3F800000.

Source files
------------

// File: rtl/fp32_accumulator.sv
// Sequential fp32 accumulator: each accepted product passes ALIGN/ADD/NORM into a running
// sum register; denormals flush to zero, rounding truncates, overflow saturates to infinity.
module fp32_accumulator #(
  parameter int CLEAR_ON_OUT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, HOLD} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_armed;
  logic [31:0] r_acc;
  logic [31:0] r_in;
  logic        r_last;

  logic [7:0]  r_big_exp;
  logic [23:0] r_big_sig;
  logic [23:0] r_sml_sig;
  logic        r_big_sign;
  logic        r_sml_sign;
  logic        r_inf;
  logic        r_inf_sign;
  logic [24:0] r_sum;
  logic        r_sum_sign;

  logic        w_accept;
  logic        w_out_hs;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_armed <= 1'b1;
    end
  end

  // r_armed keeps in_ready low while reset is held and until the first edge after release.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = r_armed;
        if (in_valid && r_armed) w_state_next = ALIGN;
      end
      ALIGN: w_state_next = ADD;
      ADD:   w_state_next = NORM;
      NORM:  w_state_next = r_last ? HOLD : IDLE;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_accept = in_valid & in_ready;
  assign w_out_hs = out_valid & out_ready;
  assign out_data = r_acc;

  // ---------------------------------------------------------------- align
  logic [7:0]  w_a_exp;
  logic [7:0]  w_b_exp;
  logic [7:0]  w_big_exp;
  logic [7:0]  w_sml_exp;
  logic [7:0]  w_diff;
  logic [23:0] w_a_sig;
  logic [23:0] w_b_sig;
  logic [23:0] w_big_sig;
  logic [23:0] w_sml_sig;
  logic [23:0] w_sml_shift;
  logic        w_swap;
  logic        w_a_inf;
  logic        w_b_inf;

  assign w_a_exp     = r_acc[30:23];
  assign w_b_exp     = r_in[30:23];
  assign w_a_sig     = (w_a_exp == 8'd0) ? 24'd0 : {1'b1, r_acc[22:0]};
  assign w_b_sig     = (w_b_exp == 8'd0) ? 24'd0 : {1'b1, r_in[22:0]};
  assign w_a_inf     = &w_a_exp;
  assign w_b_inf     = &w_b_exp;
  assign w_swap      = w_b_exp > w_a_exp;
  assign w_big_exp   = w_swap ? w_b_exp : w_a_exp;
  assign w_sml_exp   = w_swap ? w_a_exp : w_b_exp;
  assign w_big_sig   = w_swap ? w_b_sig : w_a_sig;
  assign w_sml_sig   = w_swap ? w_a_sig : w_b_sig;
  assign w_diff      = w_big_exp - w_sml_exp;
  assign w_sml_shift = (w_diff >= 8'd25) ? 24'd0 : (w_sml_sig >> w_diff);

  // ---------------------------------------------------------------- add
  logic [24:0] w_sum;
  logic        w_sum_sign;

  always_comb begin
    w_sum      = 25'd0;
    w_sum_sign = r_big_sign;
    if (r_big_sign == r_sml_sign) begin
      w_sum = {1'b0, r_big_sig} + {1'b0, r_sml_sig};
    end else if (r_big_sig >= r_sml_sig) begin
      w_sum = {1'b0, r_big_sig} - {1'b0, r_sml_sig};
    end else begin
      w_sum      = {1'b0, r_sml_sig} - {1'b0, r_big_sig};
      w_sum_sign = r_sml_sign;
    end
  end

  // ---------------------------------------------------------------- normalize
  logic [4:0]  w_lz;
  logic        w_carry;
  logic [8:0]  w_exp_wide;
  logic [22:0] w_mant;
  logic        w_uf;
  logic        w_of;
  logic [31:0] w_result;

  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (r_sum[i]) w_lz = 5'(23 - i);
    end
    w_carry    = r_sum[24];
    w_exp_wide = w_carry ? ({1'b0, r_big_exp} + 9'd1) : ({1'b0, r_big_exp} - {4'd0, w_lz});
    w_mant     = w_carry ? r_sum[23:1] : (r_sum[22:0] << w_lz);
    w_uf       = !w_carry && (r_big_exp <= {3'd0, w_lz});
    w_of       = w_carry && (w_exp_wide >= 9'd255);
    w_result   = {r_sum_sign, w_exp_wide[7:0], w_mant};
    if (r_inf) begin
      w_result = {r_inf_sign, 8'hFF, 23'd0};
    end else if ((r_sum == 25'd0) || w_uf) begin
      w_result = 32'd0;
    end else if (w_of) begin
      w_result = {r_sum_sign, 8'hFF, 23'd0};
    end
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= 32'd0;
      r_in       <= 32'd0;
      r_last     <= 1'b0;
      r_big_exp  <= 8'd0;
      r_big_sig  <= 24'd0;
      r_sml_sig  <= 24'd0;
      r_big_sign <= 1'b0;
      r_sml_sign <= 1'b0;
      r_inf      <= 1'b0;
      r_inf_sign <= 1'b0;
      r_sum      <= 25'd0;
      r_sum_sign <= 1'b0;
    end else begin
      if (w_accept) begin
        r_in   <= in_data;
        r_last <= in_last;
      end
      if (r_state == ALIGN) begin
        r_big_exp  <= w_big_exp;
        r_big_sig  <= w_big_sig;
        r_sml_sig  <= w_sml_shift;
        r_big_sign <= w_swap ? r_in[31] : r_acc[31];
        r_sml_sign <= w_swap ? r_acc[31] : r_in[31];
        r_inf      <= w_a_inf | w_b_inf;
        // An incoming infinity overrides whatever the accumulator holds.
        r_inf_sign <= w_b_inf ? r_in[31] : r_acc[31];
      end
      if (r_state == ADD) begin
        r_sum      <= w_sum;
        r_sum_sign <= w_sum_sign;
      end
      if (r_state == NORM) begin
        r_acc <= w_result;
      end else if (w_out_hs && (CLEAR_ON_OUT != 0)) begin
        r_acc <= 32'd0;
      end
    end
  end

endmodule
